spi_target_shifter: RTL
=======================

// Module: spi_target_shifter
// PURPOSE
//  SPI target (slave-side) serial engine. It answers an external SPI controller: shifts MOSI in, shifts MISO out.
//  Sits between the pads and the register/APB layer: parallel TX word in and RX word out, each with valid/ready.
//  SCK/CSn/MOSI are asynchronous to clk; they are oversampled, and clk must run well above SCK.
// PARAMETERS
//  WIDTH        8      bits per SPI word (4..32)
//  CPOL         0      SCK idle level
//  CPHA         0      0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  LSB_FIRST    0      0: MSB first on both lines; 1: LSB first
//  UNDERRUN_FILL '1    word sent when no TX word is available (WIDTH bits)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active-high
//  spi_sck_i     in   1      SCK from controller (async)
//  spi_csn_i     in   1      chip select, active-low (async)
//  spi_mosi_i    in   1      serial data in (async)
//  spi_miso_o    out  1      serial data out
//  spi_miso_oe_o out  1      MISO output enable (=selected)
//  tx_data_i     in   WIDTH  next word to transmit
//  tx_valid_i    in   1      tx_data_i valid
//  tx_ready_o    out  1      TX holding register empty
//  rx_data_o     out  WIDTH  last received word
//  rx_valid_o    out  1      rx_data_o holds an unread word
//  rx_ready_i    in   1      consumer takes rx word
//  busy_o        out  1      CSn asserted (synchronized)
//  underrun_o    out  1      1-cycle pulse: word started with TX holding empty
//  overrun_o     out  1      1-cycle pulse: word received while rx_valid_o still set
// BEHAVIOUR
//  Reset: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, busy_o=0, pulses=0, FSM=IDLE, bitcnt=0.
//  Input path: 2-FF synchronizer on each of sck/csn/mosi, plus one register for edge detect.
//    Pin-to-event latency is 3 clk. SCK high and low phases must each be >= 4 clk.
//  Edges: lead = rising if CPOL=0, else falling; trail = the opposite edge. CPHA selects sample/shift edge as above.
//  TX holding: accept when tx_valid_i && tx_ready_o; tx_ready_o drops the next cycle.
//    tx_ready_o rises in the same cycle the word moves into the shift register.
//  FSM states:
//    IDLE -> LOAD on CSn fall (sync).
//    LOAD (1 cycle): shreg <= holding if full, else UNDERRUN_FILL with underrun_o pulse.
//      bitcnt=0; drive first bit on miso_o -> SHIFT.
//    SHIFT: on sample edge, capture mosi and bitcnt++; on shift edge, present next tx bit (CPHA=1: first shift edge presents bit0, no advance).
//      At bitcnt==WIDTH after a sample -> WORD.
//    WORD (1 cycle): rx_data_o<=rx shreg and rx_valid_o<=1, unless rx_valid_o already set.
//      In that case pulse overrun_o, keep old rx_data_o, drop new word. Then -> LOAD (CSn low) or IDLE (CSn high).
//    Any state: CSn rise (sync) -> IDLE same cycle; partial word discarded, no rx_valid, bitcnt=0.
//      An unloaded holding word is kept. miso_oe_o=0.
//  rx_valid_o clears on rx_ready_i. If WORD and rx_ready_i coincide, the new word wins (rx_valid_o stays 1, no overrun).
//  busy_o = synchronized ~CSn; miso_oe_o = busy_o. miso_o is 0 when not busy.
//  Back-to-back words under continuous CSn have no gap requirement beyond the SCK phase rule.
//  rst mid-transfer: everything returns to reset values; the current word is lost. Sync flops reset to idle levels (CSn=1, SCK=CPOL).
// STRUCTURE
//  Package spi_target_pkg: state enum {IDLE,LOAD,SHIFT,WORD}, CPOL/CPHA mode constants, edge-select function.
//  Sub-module spi_in_sync: 2-FF sync + edge detect (outputs level, rise, fall). Instanced for sck, csn, mosi (level only).
//  Top holds the FSM, bit counter ($clog2(WIDTH+1) bits), TX holding, TX/RX shift registers and the RX output register.
// TESTING
//  Mode0 W8: preload tx 0xA5; controller sends 0x3C at SCK=clk/10 -> rx_data 0x3C, rx_valid 1; MISO bits 1,0,1,0,0,1,0,1.
//  No tx preloaded, controller sends 0x00 -> MISO 0xFF, underrun_o 1 pulse, rx_data 0x00.
//  rx_ready_i held 0, two words 0x11,0x22 under one CSn -> rx_data 0x11, overrun_o 1 pulse; pop -> rx_valid 0.
//  CSn deasserted after 5 bits, then full word 0x5A -> no rx_valid after abort; next rx_data 0x5A, bitcnt restarted.
//  Mode3 and mode1, LSB_FIRST=1, tx 0x81 then 0x7E refilled by tx_ready -> MISO streams 0x81,0x7E; RX matches MOSI.
//  rst asserted mid-word -> all outputs at reset values next cycle; following transfer is correct.

Source files
------------

// File: rtl/spi_target_pkg.sv
// -----------------------------------------------------------------------------
// spi_target_pkg
// Shared types and helpers for the SPI target serial engine.
//   state_t   : engine FSM states
//   CPOL_* / CPHA_* : readable names for the SPI mode parameters
//   edge_sel  : picks the sample or shift event from the synchronized SCK
//               rise/fall pulses for a given CPOL/CPHA
// -----------------------------------------------------------------------------
package spi_target_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        WORD  = 2'd3
    } state_t;

    localparam logic CPOL_IDLE_LOW     = 1'b0;
    localparam logic CPOL_IDLE_HIGH    = 1'b1;
    localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
    localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

    // Leading edge is the one leaving the idle level. With CPHA=0 the target
    // samples on the leading edge and shifts on the trailing one; CPHA=1 swaps
    // them. want_sample selects which of the two events is returned.
    function automatic logic edge_sel(input logic cpol,
                                      input logic cpha,
                                      input logic want_sample,
                                      input logic rise,
                                      input logic fall);
        logic lead;
        logic trail;
        lead  = cpol ? fall : rise;
        trail = cpol ? rise : fall;
        return (want_sample ^ cpha) ? lead : trail;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// -----------------------------------------------------------------------------
// spi_in_sync
// Two-flop synchronizer for one asynchronous pad input plus an extra register
// used for edge detection.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   level    : synchronized level
//   rise     : 1-cycle pulse on a synchronized 0->1 transition
//   fall     : 1-cycle pulse on a synchronized 1->0 transition
// RESET_VAL is the idle level of the pin so that reset never creates an edge.
// -----------------------------------------------------------------------------
module spi_in_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
            prev_reg <= RESET_VAL;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
    assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_target_shifter.sv
// -----------------------------------------------------------------------------
// spi_target_shifter
// SPI target serial engine: shifts MOSI into an RX word and MISO out of a TX
// word, with valid/ready parallel interfaces toward the register layer.
// SCK/CSn/MOSI are oversampled by clk; SCK phases must be >= 4 clk each.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   spi_sck_i          SCK from controller (async)
//   spi_csn_i          chip select, active low (async)
//   spi_mosi_i         serial data in (async)
//   spi_miso_o         serial data out (0 when not selected)
//   spi_miso_oe_o      MISO output enable (= busy_o)
//   tx_data_i/valid_i  next word to transmit; tx_ready_o = holding empty
//   rx_data_o/valid_o  last received word; rx_ready_i pops it
//   busy_o             synchronized chip select
//   underrun_o         pulse: word started with TX holding empty
//   overrun_o          pulse: word completed while rx_valid_o still set
// -----------------------------------------------------------------------------
module spi_target_shifter
    import spi_target_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter bit               CPOL          = 1'b0,
    parameter bit               CPHA          = 1'b0,
    parameter bit               LSB_FIRST     = 1'b0,
    parameter logic [WIDTH-1:0] UNDERRUN_FILL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sck_i,
    input  logic             spi_csn_i,
    input  logic             spi_mosi_i,
    output logic             spi_miso_o,
    output logic             spi_miso_oe_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             underrun_o,
    output logic             overrun_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Pad index 0 = SCK, 1 = CSn, 2 = MOSI; reset levels are the idle levels.
    localparam logic [2:0] SYNC_IDLE = {1'b0, 1'b1, logic'(CPOL)};

    logic [2:0] pad_in;
    logic [2:0] sync_level;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    assign pad_in = {spi_mosi_i, spi_csn_i, spi_sck_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_in_sync #(
            .RESET_VAL (SYNC_IDLE[gi])
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .din   (pad_in[gi]),
            .level (sync_level[gi]),
            .rise  (sync_rise[gi]),
            .fall  (sync_fall[gi])
        );
    end

    logic busy;
    logic csn_rise;
    logic mosi_level;
    logic sample_ev;
    logic shift_ev;

    assign busy       = ~sync_level[1];
    assign csn_rise   = sync_rise[1];
    assign mosi_level = sync_level[2];
    assign sample_ev  = edge_sel(CPOL, CPHA, 1'b1, sync_rise[0], sync_fall[0]);
    assign shift_ev   = edge_sel(CPOL, CPHA, 1'b0, sync_rise[0], sync_fall[0]);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   bitcnt_reg;
    logic [WIDTH-1:0]   hold_reg;
    logic               hold_full_reg;
    logic [WIDTH-1:0]   tx_shreg_reg;
    logic [WIDTH-1:0]   rx_shreg_reg;
    logic [WIDTH-1:0]   rx_data_reg;
    logic               rx_valid_reg;
    logic               underrun_reg;
    logic               overrun_reg;
    logic               first_shift_reg;

    // Next-state logic; a CSn rise aborts from any state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (busy) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (sample_ev && (bitcnt_reg == CNT_W'(WIDTH - 1))) state_next = WORD;
            WORD:    state_next = busy ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
        if (csn_rise) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            bitcnt_reg      <= '0;
            hold_reg        <= '0;
            hold_full_reg   <= 1'b0;
            tx_shreg_reg    <= '0;
            rx_shreg_reg    <= '0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            underrun_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
            first_shift_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            underrun_reg <= 1'b0;
            overrun_reg  <= 1'b0;

            // Holding register accepts only while empty, so it never collides
            // with the LOAD transfer below (which only fires when full).
            if (tx_valid_i && !hold_full_reg) begin
                hold_reg      <= tx_data_i;
                hold_full_reg <= 1'b1;
            end

            if (rx_ready_i) begin
                rx_valid_reg <= 1'b0;
            end

            if (csn_rise) begin
                bitcnt_reg <= '0;
            end else begin
                case (state_reg)
                    LOAD: begin
                        if (hold_full_reg) begin
                            tx_shreg_reg  <= hold_reg;
                            hold_full_reg <= 1'b0;
                        end else begin
                            tx_shreg_reg <= UNDERRUN_FILL;
                            underrun_reg <= 1'b1;
                        end
                        bitcnt_reg      <= '0;
                        first_shift_reg <= 1'b1;
                    end
                    SHIFT: begin
                        if (sample_ev) begin
                            rx_shreg_reg <= LSB_FIRST ? {mosi_level, rx_shreg_reg[WIDTH-1:1]}
                                                      : {rx_shreg_reg[WIDTH-2:0], mosi_level};
                            bitcnt_reg   <= bitcnt_reg + 1'b1;
                        end
                        if (shift_ev) begin
                            if (CPHA == CPHA_SAMPLE_LEAD) begin
                                // A trail edge with bitcnt==0 belongs to the
                                // last bit of the previous word; ignore it.
                                if (bitcnt_reg != '0) begin
                                    tx_shreg_reg <= LSB_FIRST ? {1'b0, tx_shreg_reg[WIDTH-1:1]}
                                                              : {tx_shreg_reg[WIDTH-2:0], 1'b0};
                                end
                            end else begin
                                // First leading edge only re-presents bit 0.
                                if (first_shift_reg) begin
                                    first_shift_reg <= 1'b0;
                                end else begin
                                    tx_shreg_reg <= LSB_FIRST ? {1'b0, tx_shreg_reg[WIDTH-1:1]}
                                                              : {tx_shreg_reg[WIDTH-2:0], 1'b0};
                                end
                            end
                        end
                    end
                    WORD: begin
                        // A simultaneous pop frees the output, so the new word wins.
                        if (rx_valid_reg && !rx_ready_i) begin
                            overrun_reg <= 1'b1;
                        end else begin
                            rx_data_reg  <= rx_shreg_reg;
                            rx_valid_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic tx_bit;
    assign tx_bit = LSB_FIRST ? tx_shreg_reg[0] : tx_shreg_reg[WIDTH-1];

    assign spi_miso_o    = busy & tx_bit;
    assign spi_miso_oe_o = busy;
    assign busy_o        = busy;
    assign tx_ready_o    = ~hold_full_reg;
    assign rx_data_o     = rx_data_reg;
    assign rx_valid_o    = rx_valid_reg;
    assign underrun_o    = underrun_reg;
    assign overrun_o     = overrun_reg;

    // SCK level and MOSI edges are not needed; first_shift is idle in CPHA=0.
    logic unused_sync;
    assign unused_sync = ^{sync_level[0], sync_rise[2], sync_fall[2], first_shift_reg};

endmodule
